// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg
//   Shared types for the SRAM port arbiter.
//   - rsp_owner_e      : who the SRAM read data belongs to in the cycle after a grant
//   - STARVE_W         : width of the fetch starvation counter
//   - owner_from_grant : maps the current grant to the owner of next cycle's response
package sram_arb_pkg;

    localparam int STARVE_W = 4;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        IF    = 2'd1,
        DS_RD = 2'd2,
        DS_WR = 2'd3
    } rsp_owner_e;

    // A fetch granted together with a flush is already cancelled, so its
    // response slot is recorded as unowned and the read data is dropped.
    function automatic rsp_owner_e owner_from_grant(input logic if_grant,
                                                    input logic ds_grant,
                                                    input logic ds_write,
                                                    input logic if_flush);
        if (ds_grant) begin
            return ds_write ? DS_WR : DS_RD;
        end
        if (if_grant && !if_flush) begin
            return IF;
        end
        return NONE;
    endfunction

endpackage

// File: rtl/sram_arb_grant.sv
// sram_arb_grant
//   Purely combinational two-requester priority with starvation override.
//   The data side normally wins; once the fetch side has been denied
//   STARVE_MAX consecutive cycles it is forced to win while it is requesting.
// Ports:
//   grant_en   : global grant enable (low blocks every grant)
//   if_valid   : fetch requester is asking for the SRAM
//   ds_valid   : data requester is asking for the SRAM
//   starve_cnt : consecutive denied fetch cycles so far
//   if_grant   : fetch wins this cycle
//   ds_grant   : data wins this cycle
module sram_arb_grant
    import sram_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic                grant_en,
    input  logic                if_valid,
    input  logic                ds_valid,
    input  logic [STARVE_W-1:0] starve_cnt,
    output logic                if_grant,
    output logic                ds_grant
);

    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    logic force_if;

    always_comb begin
        force_if = (starve_cnt >= STARVE_LIM);
        // The override only matters when fetch is actually requesting;
        // otherwise data proceeds as usual.
        ds_grant = grant_en && ds_valid && !(force_if && if_valid);
        if_grant = grant_en && if_valid && !ds_grant;
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//   Shares one single-ported, 1-cycle-latency synchronous SRAM between the
//   instruction-fetch requester and the data requester. At most one access
//   is granted per cycle; its response is routed to the owner one cycle later.
//
// Handshake: a request is transferred in a cycle where both *_req_valid and
//   *_req_ready are high. ready is combinational from valid and never
//   required before valid; a requester keeps valid and its payload stable
//   until it sees ready. Responses have no ready: *_rsp_valid is a single
//   cycle pulse that must be accepted.
//
// Ports:
//   clk, resetn                 : clock, asynchronous active-low reset
//   if_req_valid/addr/ready     : fetch read request channel
//   if_flush                    : cancels an in-flight or same-cycle fetch response
//   if_rsp_valid/rdata          : fetch response
//   ds_req_valid/we/addr/wdata/ready : data request channel (we == 0 is a read)
//   ds_rsp_valid/rdata          : data response (rdata is 0 for a write ack)
//   sram_en/we/addr/wdata/rdata : SRAM macro interface
//   starve_cnt                  : debug view of the fetch starvation counter
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                if_req_valid,
    input  logic [ADDR_W-1:0]   if_req_addr,
    output logic                if_req_ready,
    input  logic                if_flush,
    output logic                if_rsp_valid,
    output logic [DATA_W-1:0]   if_rsp_rdata,
    input  logic                ds_req_valid,
    input  logic [DATA_W/8-1:0] ds_req_we,
    input  logic [ADDR_W-1:0]   ds_req_addr,
    input  logic [DATA_W-1:0]   ds_req_wdata,
    output logic                ds_req_ready,
    output logic                ds_rsp_valid,
    output logic [DATA_W-1:0]   ds_rsp_rdata,
    output logic                sram_en,
    output logic [DATA_W/8-1:0] sram_we,
    output logic [ADDR_W-1:0]   sram_addr,
    output logic [DATA_W-1:0]   sram_wdata,
    input  logic [DATA_W-1:0]   sram_rdata,
    output logic [STARVE_W-1:0] starve_cnt
);

    logic       if_grant;
    logic       ds_grant;
    rsp_owner_e rsp_owner;
    rsp_owner_e rsp_owner_nxt;

    // Grants are gated by resetn so nothing reaches the SRAM while in reset.
    sram_arb_grant #(
        .STARVE_MAX (STARVE_MAX)
    ) u_grant (
        .grant_en   (resetn),
        .if_valid   (if_req_valid),
        .ds_valid   (ds_req_valid),
        .starve_cnt (starve_cnt),
        .if_grant   (if_grant),
        .ds_grant   (ds_grant)
    );

    assign if_req_ready = if_grant;
    assign ds_req_ready = ds_grant;

    always_comb begin
        sram_en    = if_grant || ds_grant;
        sram_we    = '0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (ds_grant) begin
            sram_we    = ds_req_we;
            sram_addr  = ds_req_addr;
            sram_wdata = ds_req_wdata;
        end else if (if_grant) begin
            sram_addr  = if_req_addr;
        end
    end

    // Response owner: state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rsp_owner <= NONE;
        end else begin
            rsp_owner <= rsp_owner_nxt;
        end
    end

    // Response owner: next state, reloaded every cycle from the grant
    always_comb begin
        rsp_owner_nxt = owner_from_grant(if_grant, ds_grant, |ds_req_we, if_flush);
    end

    // Response owner: outputs. A flush arriving in the response cycle still
    // suppresses the fetch response; data responses ignore flush.
    always_comb begin
        if_rsp_valid = 1'b0;
        if_rsp_rdata = '0;
        ds_rsp_valid = 1'b0;
        ds_rsp_rdata = '0;
        case (rsp_owner)
            IF: begin
                if (!if_flush) begin
                    if_rsp_valid = 1'b1;
                    if_rsp_rdata = sram_rdata;
                end
            end
            DS_RD: begin
                ds_rsp_valid = 1'b1;
                ds_rsp_rdata = sram_rdata;
            end
            DS_WR: begin
                ds_rsp_valid = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Consecutive cycles fetch asked and lost; saturates instead of wrapping
    // so a long denial can never look like a short one.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            starve_cnt <= '0;
        end else if (!if_req_valid || if_grant) begin
            starve_cnt <= '0;
        end else if (starve_cnt != '1) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule
